// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding, the default
// data-streak limit and the program-counter bus range.
// Optional feature macro: ARB_FETCH_BUF_EN (one-entry fetch line buffer).
`ifndef PC_BUS
`define PC_BUS 31:0
`endif

package mem_port_arb_pkg;

  // Two-bit arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2
  } arb_state_t;

  // Consecutive data grants allowed while a fetch waits
  localparam int unsigned MAX_DSTREAK_DEF = 4;

  // Tag width of a 64-bit line address (bits [31:3])
  localparam int unsigned TAG_W = 29;

  // Align a byte address to its 64-bit instruction pair
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_port_arb_fetch_line_buf.sv
// One-entry fetch line buffer: remembers the last completed fetch line so a
// repeated fetch of the same 64-bit pair can be answered without memory.
// Built only when ARB_FETCH_BUF_EN is defined.
`ifdef ARB_FETCH_BUF_EN
module fetch_line_buf
  import mem_port_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data,
  input  logic             inv,
  input  logic [TAG_W-1:0] inv_tag,
  input  logic [TAG_W-1:0] look_tag,
  output logic             hit,
  output logic [63:0]      data
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [63:0]      line;

  // Entry register: fill on fetch completion, drop on a write to the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      line  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      line  <= fill_data;
    end else if (inv && (inv_tag == tag)) begin
      valid <= 1'b0;
    end
  end

  // Lookup against the current fetch address
  always_comb begin
    hit  = valid && (tag == look_tag);
    data = line;
  end

endmodule
`endif

// File: rtl/mem_port_arb.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Data wins ties until MAX_DSTREAK consecutive data grants have been made
// while a fetch waits; then the fetch goes. A branch redirect makes an
// in-flight fetch stale so its completion is swallowed.
// Optional feature macro: ARB_FETCH_BUF_EN adds a one-entry fetch line buffer.
//
// Handshakes: d_req and its fields are held by the requester until the
// one-cycle d_ack; mem_req and its fields are held by this block until the
// memory answers with mem_ack, which is only meaningful while mem_req=1.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int unsigned MEM_LAT_CHK = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [`PC_BUS] if_addr,
  input  logic           branch_flag,
  output logic           inst_valid,
  output logic [63:0]    inst_out,
  output logic           if_stop,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [31:0]    d_addr,
  input  logic [31:0]    d_wdata,
  input  logic [3:0]     d_be,
  output logic           d_ack,
  output logic [31:0]    d_rdata,
  output logic           mem_req,
  output logic           mem_we,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wdata,
  output logic [3:0]     mem_be,
  input  logic           mem_ack,
  input  logic [63:0]    mem_rdata,
  output logic [1:0]     dbg_state
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 2);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] dstreak;
  logic          drop;
  logic          drop_now;
  logic          inst_valid_q;
  logic          may_grant;
  logic          if_elig;
  logic          grant_d;
  logic          grant_f;
  logic          grant_mem_f;
  logic          grant_hit;
  logic          fetch_done;
  logic          buf_hit;
  logic [63:0]   buf_data;
  logic          unused_ok;

  // Address bits below the line and the reserved parameter carry no function
  assign unused_ok = ^{if_addr[2:0], 1'(MEM_LAT_CHK)};

`ifdef ARB_FETCH_BUF_EN
  fetch_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (fetch_done),
    .fill_tag  (mem_addr[31:3]),
    .fill_data (mem_rdata),
    .inv       (grant_d & d_we),
    .inv_tag   (d_addr[31:3]),
    .look_tag  (if_addr[31:3]),
    .hit       (buf_hit),
    .data      (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: leave IDLE on a memory grant, return on mem_ack
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_d)          state_nxt = ST_D_BUSY;
        else if (grant_mem_f) state_nxt = ST_IF_BUSY;
      end
      ST_IF_BUSY: if (mem_ack) state_nxt = ST_IDLE;
      ST_D_BUSY:  if (mem_ack) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Grant decision: no grant while a completion pulse is out, no fetch on a redirect
  always_comb begin
    may_grant = (state == ST_IDLE) && !inst_valid_q && !d_ack;
    if_elig   = if_req && !branch_flag;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    if (may_grant) begin
      if (d_req && if_elig) begin
        if (dstreak == SW'(MAX_DSTREAK)) grant_f = 1'b1;
        else                             grant_d = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (if_elig) begin
        grant_f = 1'b1;
      end
    end
    grant_hit   = grant_f && buf_hit;
    grant_mem_f = grant_f && !buf_hit;
    drop_now    = drop || branch_flag;
    fetch_done  = (state == ST_IF_BUSY) && mem_ack && !drop_now;
  end

  // Data streak counter; saturates so a blocked fetch keeps its turn
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       dstreak <= '0;
    else if (!if_req || grant_f)                    dstreak <= '0;
    else if (grant_d && dstreak != SW'(MAX_DSTREAK)) dstreak <= dstreak + SW'(1);
  end

  // Stale-fetch flag: set by a redirect during a fetch, cleared on return to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       drop <= 1'b0;
    else if (state_nxt == ST_IDLE)                  drop <= 1'b0;
    else if (state == ST_IF_BUSY && branch_flag)    drop <= 1'b1;
  end

  // Memory port request and its fields, held from grant until mem_ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant_mem_f) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= line_addr(if_addr[31:0]);
      mem_wdata <= '0;
      mem_be    <= 4'hF;
    end else if (mem_req && mem_ack) begin
      mem_req   <= 1'b0;
    end
  end

  // Completion pulses and returned data for both requesters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid_q <= 1'b0;
      inst_out     <= '0;
      d_ack        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      d_ack        <= 1'b0;
      if (fetch_done) begin
        inst_out     <= mem_rdata;
        inst_valid_q <= 1'b1;
      end else if (grant_hit) begin
        inst_out     <= buf_data;
        inst_valid_q <= 1'b1;
      end
      if (state == ST_D_BUSY && mem_ack) begin
        d_rdata <= d_addr[2] ? mem_rdata[31:0] : mem_rdata[63:32];
        d_ack   <= 1'b1;
      end
    end
  end

  // A redirect in the pulse cycle kills the instruction pair on the spot
  always_comb begin
    inst_valid = inst_valid_q && !branch_flag;
    if_stop    = if_req && !inst_valid;
    dbg_state  = state;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: fetch and data paths, arbitration streak,
// branch redirect handling, asynchronous reset and the optional line buffer.
`timescale 1ns/1ps
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        branch_flag = 1'b0;
  logic        inst_valid;
  logic [63:0] inst_out;
  logic        if_stop;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int ack_cnt   = 0;
  logic stray = 1'b0;
  int n_inst  = 0;
  int n_dack  = 0;
  int n_grant = 0;
  logic req_prev = 1'b0;
  logic [7:0] grant_q[$];
  logic [7:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  mem_port_arb #(.MAX_DSTREAK(4), .MEM_LAT_CHK(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .branch_flag (branch_flag),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .if_stop     (if_stop),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // Memory content model: address-derived 64-bit pattern
  function automatic logic [63:0] mdata(input logic [31:0] a);
    return {a ^ 32'hCAFE_0000, a ^ 32'h0000_BEEF};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory responder: ack after ack_delay cycles of mem_req
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray) begin
        mem_ack = 1'b1;
      end else if (rst && mem_req) begin
        if (ack_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mdata(mem_addr);
          ack_cnt   = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Monitor: completion pulses and grant order ("F" = fetch at 0x300)
  initial begin
    forever begin
      @(negedge clk);
      if (inst_valid) n_inst++;
      if (d_ack)      n_dack++;
      if (mem_req && !req_prev) begin
        n_grant++;
        grant_q.push_back((mem_addr == 32'h0000_0300) ? 8'h46 : 8'h44);
      end
      req_prev = mem_req;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] m;
    int saved;
    int base;

    // Reset state
    step(3);
    check("rst_mem_req",  mem_req,    0);
    check("rst_inst_val", inst_valid, 0);
    check("rst_d_ack",    d_ack,      0);
    check("rst_mem_addr", mem_addr,   0);
    check("rst_state",    dbg_state,  ST_IDLE);
    check("rst_if_stop",  if_stop,    0);
    rst = 1'b1;
    step(1);

    // Fetch 0x104, ack on first mem_req cycle
    ack_delay = 0;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    #1;
    check("f1_if_stop_c1", if_stop, 1);
    step(1);
    check("f1_mem_req",  mem_req,   1);
    check("f1_mem_addr", mem_addr,  32'h0000_0100);
    check("f1_mem_we",   mem_we,    0);
    check("f1_mem_be",   mem_be,    4'hF);
    check("f1_state",    dbg_state, ST_IF_BUSY);
    step(1);
    check("f1_inst_valid_c3", inst_valid, 1);
    check("f1_inst_out",      inst_out,   mdata(32'h0000_0100));
    check("f1_if_stop_c3",    if_stop,    0);
    check("f1_state_idle",    dbg_state,  ST_IDLE);
    if_req = 1'b0;
    step(1);
    check("f1_pulse_len", inst_valid, 0);

    // Stray mem_ack in IDLE is ignored
    stray = 1'b1;
    step(1);
    stray = 1'b0;
    check("stray_state", dbg_state, ST_IDLE);
    check("stray_dack",  d_ack,     0);
    check("stray_inst",  inst_valid, 0);
    step(1);
    check("stray_dack2", d_ack, 0);

    // Data reads: upper/lower half select, back-to-back idle gap
    ack_delay = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1004; d_be = 4'hF;
    step(1);
    check("dr_mem_req",  mem_req,   1);
    check("dr_mem_addr", mem_addr,  32'h0000_1004);
    check("dr_state",    dbg_state, ST_D_BUSY);
    step(1);
    check("dr_hold", mem_req, 1);
    step(1);
    m = mdata(32'h0000_1004);
    check("dr_ack",   d_ack,   1);
    check("dr_lo",    d_rdata, m[31:0]);
    check("dr_req0",  mem_req, 0);
    d_addr = 32'h0000_1000;
    ack_delay = 0;
    step(1);
    check("b2b_gap_req",  mem_req, 0);
    check("b2b_gap_dack", d_ack,   0);
    step(1);
    check("b2b_req",  mem_req,  1);
    check("b2b_addr", mem_addr, 32'h0000_1000);
    step(1);
    m = mdata(32'h0000_1000);
    check("dr2_ack", d_ack,   1);
    check("dr2_hi",  d_rdata, m[63:32]);
    d_req = 1'b0;
    step(1);

    // Data write fields
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3008; d_wdata = 32'h1234_5678; d_be = 4'h3;
    step(1);
    check("dw_we",    mem_we,    1);
    check("dw_wdata", mem_wdata, 32'h1234_5678);
    check("dw_be",    mem_be,    4'h3);
    check("dw_addr",  mem_addr,  32'h0000_3008);
    step(1);
    check("dw_ack", d_ack, 1);
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    step(1);

    // Streak: both held, expect D,D,D,D,F repeating
    grant_q.delete();
    ack_delay = 0;
    d_req = 1'b1; d_addr = 32'h0000_2000;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    step(33);
    d_req = 1'b0; if_req = 1'b0;
    step(5);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h44); exp_q.push_back(8'h44); exp_q.push_back(8'h44);
      exp_q.push_back(8'h44); exp_q.push_back(8'h46);
    end
    check("streak_count_ge10", grant_q.size() >= 10, 1);
    for (int i = 0; i < 10 && grant_q.size() > 0; i++) begin
      logic [7:0] g, e;
      g = grant_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("streak_grant%0d", i), g, e);
    end
    exp_q.delete();
    step(2);

    // Redirect blocks a fetch grant but not a data grant
    branch_flag = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0600;
    step(1);
    check("br_block_req",   mem_req,   0);
    check("br_block_state", dbg_state, ST_IDLE);
    branch_flag = 1'b0;
    step(1);
    check("br_after_req",  mem_req,  1);
    check("br_after_addr", mem_addr, 32'h0000_0600);
    step(1);
    check("br_after_inst", inst_valid, 1);
    if_req = 1'b0;
    step(1);
    branch_flag = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1008;
    step(1);
    check("br_data_req",  mem_req,  1);
    check("br_data_addr", mem_addr, 32'h0000_1008);
    branch_flag = 1'b0;
    step(1);
    check("br_data_ack", d_ack, 1);
    d_req = 1'b0;
    step(1);

    // Redirect during IF_BUSY, ack two cycles later: no instruction
    ack_delay = 2;
    if_req = 1'b1; if_addr = 32'h0000_0400;
    step(1);
    check("drop_busy", dbg_state, ST_IF_BUSY);
    branch_flag = 1'b1; if_req = 1'b0;
    saved = n_inst;
    step(1);
    branch_flag = 1'b0;
    step(1);
    check("drop_still_busy", mem_req, 1);
    step(1);
    check("drop_state_idle", dbg_state, ST_IDLE);
    check("drop_no_inst",    inst_valid, 0);
    step(1);
    check("drop_no_inst2", inst_valid, 0);
    check("drop_inst_cnt", n_inst, saved);

    // Redirect in the pulse cycle suppresses inst_valid
    ack_delay = 0;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    step(2);
    check("sup_pre", inst_valid, 1);
    saved = n_inst;
    branch_flag = 1'b1; if_req = 1'b0;
    #1;
    check("sup_inst", inst_valid, 0);
    step(1);
    branch_flag = 1'b0;
    check("sup_cnt", n_inst, saved);
    step(1);

    // Reset while mem_req is high: immediate clear, no late d_ack
    ack_delay = 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3010; d_wdata = 32'hDEAD_BEEF;
    step(1);
    check("rmid_req_pre", mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rmid_req",   mem_req,   0);
    check("rmid_we",    mem_we,    0);
    check("rmid_addr",  mem_addr,  0);
    check("rmid_state", dbg_state, ST_IDLE);
    d_req = 1'b0; d_we = 1'b0;
    saved = n_dack;
    step(2);
    rst = 1'b1;
    step(10);
    check("rmid_no_dack", n_dack, saved);
    check("rmid_req_end", mem_req, 0);

`ifdef ARB_FETCH_BUF_EN
    // Line buffer: repeat fetch served locally, write to the line invalidates
    ack_delay = 0;
    base = n_grant;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    step(2);
    check("buf_fill_inst", inst_valid, 1);
    if_req = 1'b0;
    step(1);
    if_req = 1'b1;
    step(1);
    check("buf_hit_inst", inst_valid, 1);
    check("buf_hit_data", inst_out,   mdata(32'h0000_0200));
    check("buf_hit_noreq", mem_req,   0);
    if_req = 1'b0;
    step(1);
    check("buf_one_grant", n_grant, base + 1);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0204;
    step(2);
    check("buf_wr_ack", d_ack, 1);
    d_req = 1'b0; d_we = 1'b0;
    step(1);
    if_req = 1'b1;
    step(1);
    check("buf_miss_req", mem_req, 1);
    step(1);
    check("buf_miss_inst", inst_valid, 1);
    if_req = 1'b0;
    step(1);
    check("buf_grants", n_grant, base + 3);
`else
    base = n_grant;
    saved = base;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
